// File: rtl/evm_result_controller.sv
// EVM mode/result controller: vote acknowledge, tally display
// and a sequential winner scan with tie detection.
module evm_result_controller #(
  parameter  int NUM_CAND    = 4,
  parameter  int CNT_W       = 4,
  parameter  int HOLD_CYCLES = 10,
  localparam int IDX_W       = $clog2(NUM_CAND)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      mode,
  input  logic                      valid_vote_casted,
  input  logic [NUM_CAND*CNT_W-1:0] cand_votes,
  input  logic [NUM_CAND-1:0]       cand_button_press,
  input  logic                      show_winner,
  output logic [CNT_W-1:0]          result,
  output logic [IDX_W-1:0]          result_idx,
  output logic                      result_valid,
  output logic                      vote_ack,
  output logic                      tie
);

  localparam int HC_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(HOLD_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  typedef enum logic [2:0] {
    VOTE,
    ACK,
    RESULT,
    SCAN,
    WINNER
  } state_t;

  state_t            state_q, state_d;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [IDX_W-1:0]  scan_q, scan_d;
  logic [CNT_W-1:0]  max_q, max_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic              tacc_q, tacc_d;

  logic [CNT_W-1:0]  result_d;
  logic [IDX_W-1:0]  result_idx_d;
  logic              result_valid_d;
  logic              vote_ack_d;
  logic              tie_d;

  logic [CNT_W-1:0]  tally [NUM_CAND];
  logic              press;
  logic [IDX_W-1:0]  press_idx;
  logic [CNT_W-1:0]  scan_v;
  logic [CNT_W-1:0]  nmax;
  logic [IDX_W-1:0]  nwidx;
  logic              ntie;

  always_comb begin
    for (int i = 0; i < NUM_CAND; i++) begin
      tally[i] = cand_votes[i*CNT_W +: CNT_W];
    end
  end

  // Lowest-index button wins when several are pressed together
  always_comb begin
    press_idx = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (cand_button_press[i]) press_idx = IDX_W'(i);
    end
  end

  assign press = |cand_button_press;

  always_comb begin
    scan_v = tally[scan_q];
    nmax   = max_q;
    nwidx  = widx_q;
    ntie   = tacc_q;
    if (scan_q == '0) begin
      nmax  = scan_v;
      nwidx = '0;
      ntie  = 1'b0;
    end else if (scan_v > max_q) begin
      nmax  = scan_v;
      nwidx = scan_q;
      ntie  = 1'b0;
    end else if (scan_v == max_q) begin
      ntie  = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    sel_d          = sel_q;
    scan_d         = scan_q;
    max_d          = max_q;
    widx_d         = widx_q;
    tacc_d         = tacc_q;
    result_d       = result;
    result_idx_d   = result_idx;
    result_valid_d = result_valid;
    vote_ack_d     = vote_ack;
    tie_d          = tie;

    unique case (state_q)
      VOTE: begin
        result_d       = '0;
        result_idx_d   = '0;
        result_valid_d = 1'b0;
        vote_ack_d     = 1'b0;
        tie_d          = 1'b0;
        hold_d         = '0;
        if (mode) begin
          state_d = RESULT;
        end else if (valid_vote_casted) begin
          state_d    = ACK;
          hold_d     = HC_W'(1);
          result_d   = '1;
          vote_ack_d = 1'b1;
        end
      end

      ACK: begin
        if (mode) begin
          state_d    = RESULT;
          hold_d     = '0;
          result_d   = '0;
          vote_ack_d = 1'b0;
        end else if (valid_vote_casted) begin
          hold_d = HC_W'(1);
        end else if (hold_q == HOLD_MAX) begin
          state_d    = VOTE;
          hold_d     = '0;
          result_d   = '0;
          vote_ack_d = 1'b0;
        end else begin
          hold_d = hold_q + HC_W'(1);
        end
      end

      RESULT: begin
        if (!mode) begin
          state_d        = VOTE;
          result_d       = '0;
          result_idx_d   = '0;
          result_valid_d = 1'b0;
          tie_d          = 1'b0;
        end else if (show_winner) begin
          state_d        = SCAN;
          scan_d         = '0;
          result_d       = '0;
          result_idx_d   = '0;
          result_valid_d = 1'b0;
          tie_d          = 1'b0;
        end else if (press) begin
          sel_d          = press_idx;
          result_d       = tally[press_idx];
          result_idx_d   = press_idx;
          result_valid_d = 1'b1;
          tie_d          = 1'b0;
        end else if (result_valid) begin
          result_d = tally[sel_q];
        end
      end

      SCAN: begin
        if (!mode) begin
          state_d        = VOTE;
          result_d       = '0;
          result_idx_d   = '0;
          result_valid_d = 1'b0;
          tie_d          = 1'b0;
        end else begin
          max_d  = nmax;
          widx_d = nwidx;
          tacc_d = ntie;
          if (scan_q == LAST_IDX) begin
            state_d        = WINNER;
            result_d       = nmax;
            result_idx_d   = nwidx;
            result_valid_d = 1'b1;
            tie_d          = ntie;
          end else begin
            scan_d = scan_q + IDX_W'(1);
          end
        end
      end

      WINNER: begin
        if (!mode) begin
          state_d        = VOTE;
          result_d       = '0;
          result_idx_d   = '0;
          result_valid_d = 1'b0;
          tie_d          = 1'b0;
        end else if (show_winner) begin
          state_d        = SCAN;
          scan_d         = '0;
          result_d       = '0;
          result_idx_d   = '0;
          result_valid_d = 1'b0;
          tie_d          = 1'b0;
        end else if (press) begin
          state_d        = RESULT;
          sel_d          = press_idx;
          result_d       = tally[press_idx];
          result_idx_d   = press_idx;
          result_valid_d = 1'b1;
          tie_d          = 1'b0;
        end
      end

      default: begin
        state_d        = VOTE;
        hold_d         = '0;
        result_d       = '0;
        result_idx_d   = '0;
        result_valid_d = 1'b0;
        vote_ack_d     = 1'b0;
        tie_d          = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= VOTE;
      hold_q       <= '0;
      sel_q        <= '0;
      scan_q       <= '0;
      max_q        <= '0;
      widx_q       <= '0;
      tacc_q       <= 1'b0;
      result       <= '0;
      result_idx   <= '0;
      result_valid <= 1'b0;
      vote_ack     <= 1'b0;
      tie          <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      sel_q        <= sel_d;
      scan_q       <= scan_d;
      max_q        <= max_d;
      widx_q       <= widx_d;
      tacc_q       <= tacc_d;
      result       <= result_d;
      result_idx   <= result_idx_d;
      result_valid <= result_valid_d;
      vote_ack     <= vote_ack_d;
      tie          <= tie_d;
    end
  end

endmodule

// File: tb/tb_evm_result_controller.sv
// Directed bench for evm_result_controller (N=4, CNT_W=4,
// HOLD_CYCLES=10).
module tb_evm_result_controller;

  logic        clock;
  logic        reset;
  logic        mode;
  logic        valid_vote_casted;
  logic [15:0] cand_votes;
  logic [3:0]  cand_button_press;
  logic        show_winner;
  logic [3:0]  result;
  logic [1:0]  result_idx;
  logic        result_valid;
  logic        vote_ack;
  logic        tie;

  int checks = 0;
  int errors = 0;
  int cnt;

  evm_result_controller #(
    .NUM_CAND(4),
    .CNT_W(4),
    .HOLD_CYCLES(10)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mode(mode),
    .valid_vote_casted(valid_vote_casted),
    .cand_votes(cand_votes),
    .cand_button_press(cand_button_press),
    .show_winner(show_winner),
    .result(result),
    .result_idx(result_idx),
    .result_valid(result_valid),
    .vote_ack(vote_ack),
    .tie(tie)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_result"}, 32'(result), 0);
    chk({tag, "_idx"}, 32'(result_idx), 0);
    chk({tag, "_valid"}, 32'(result_valid), 0);
    chk({tag, "_ack"}, 32'(vote_ack), 0);
    chk({tag, "_tie"}, 32'(tie), 0);
  endtask

  initial begin
    reset = 1'b1;
    mode = 1'b0;
    valid_vote_casted = 1'b0;
    cand_votes = '0;
    cand_button_press = '0;
    show_winner = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();

    // single acknowledge
    valid_vote_casted = 1'b1;
    tick();
    valid_vote_casted = 1'b0;
    chk("ack_pattern", 32'(result), 32'hf);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (vote_ack && result == 4'hf) cnt++;
      tick();
    end
    chk("ack_len", 32'(cnt), 10);
    chk("ack_done_result", 32'(result), 0);

    // restart during ACK extends the hold
    valid_vote_casted = 1'b1;
    tick();
    valid_vote_casted = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      if (vote_ack) cnt++;
      if (c == 5) valid_vote_casted = 1'b1;
      tick();
      valid_vote_casted = 1'b0;
    end
    chk("ack_ext_len", 32'(cnt), 15);

    // mode change aborts ACK
    valid_vote_casted = 1'b1;
    tick();
    valid_vote_casted = 1'b0;
    tick();
    tick();
    tick();
    chk("ack_mid", 32'(vote_ack), 1);
    mode = 1'b1;
    tick();
    chk_zero("abort");
    valid_vote_casted = 1'b1;
    tick();
    valid_vote_casted = 1'b0;
    chk("result_ignores_vote", 32'(vote_ack), 0);
    chk("no_sel_valid", 32'(result_valid), 0);

    // selection and live tracking
    cand_votes = 16'h9273;
    cand_button_press = 4'b0110;
    tick();
    cand_button_press = 4'b0000;
    chk("sel_result", 32'(result), 7);
    chk("sel_idx", 32'(result_idx), 1);
    chk("sel_valid", 32'(result_valid), 1);
    tick();
    chk("sel_keep", 32'(result), 7);
    cand_votes = 16'h9283;
    tick();
    chk("sel_live", 32'(result), 8);

    // winner scan; show_winner beats a button
    cand_votes = 16'h9273;
    show_winner = 1'b1;
    cand_button_press = 4'b0001;
    tick();
    show_winner = 1'b0;
    cand_button_press = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      chk("scan_valid_low", 32'(result_valid), 0);
      tick();
    end
    chk("win_result", 32'(result), 9);
    chk("win_idx", 32'(result_idx), 3);
    chk("win_tie", 32'(tie), 0);
    chk("win_valid", 32'(result_valid), 1);
    cand_votes = 16'h1273;
    tick();
    chk("win_frozen", 32'(result), 9);

    // tie case
    cand_votes = 16'h1979;
    show_winner = 1'b1;
    tick();
    show_winner = 1'b0;
    repeat (4) tick();
    chk("tie_result", 32'(result), 9);
    chk("tie_idx", 32'(result_idx), 0);
    chk("tie_flag", 32'(tie), 1);
    cand_button_press = 4'b0100;
    tick();
    cand_button_press = 4'b0000;
    chk("win2res_result", 32'(result), 9);
    chk("win2res_idx", 32'(result_idx), 2);
    chk("win2res_tie", 32'(tie), 0);
    chk("win2res_valid", 32'(result_valid), 1);

    // unsigned compare: 15 beats 14
    cand_votes = 16'h2f0e;
    show_winner = 1'b1;
    tick();
    show_winner = 1'b0;
    repeat (4) tick();
    chk("uns_result", 32'(result), 15);
    chk("uns_idx", 32'(result_idx), 2);
    chk("uns_tie", 32'(tie), 0);

    // abort scan on its second cycle
    show_winner = 1'b1;
    tick();
    show_winner = 1'b0;
    tick();
    mode = 1'b0;
    valid_vote_casted = 1'b1;
    tick();
    valid_vote_casted = 1'b0;
    chk_zero("scan_abort");
    tick();
    chk("abort_no_ack", 32'(vote_ack), 0);
    valid_vote_casted = 1'b1;
    tick();
    valid_vote_casted = 1'b0;
    chk("resume_ack", 32'(vote_ack), 1);
    repeat (12) tick();
    chk("resume_ack_end", 32'(vote_ack), 0);

    // async reset in WINNER
    mode = 1'b1;
    tick();
    show_winner = 1'b1;
    tick();
    show_winner = 1'b0;
    repeat (4) tick();
    chk("pre_rst_valid", 32'(result_valid), 1);
    #3;
    reset = 1'b1;
    #1;
    chk_zero("async_rst");
    tick();
    reset = 1'b0;
    mode = 1'b0;
    valid_vote_casted = 1'b1;
    tick();
    valid_vote_casted = 1'b0;
    chk("post_rst_ack", 32'(vote_ack), 1);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (vote_ack && result == 4'hf) cnt++;
      tick();
    end
    chk("post_rst_len", 32'(cnt), 10);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/evm_result_controller.md
Name: evm_result_controller

Overview:
- Parametrised successor to the EVM mode/result controller: N candidates, CNT_W-bit tallies, configurable vote-acknowledge hold time.
- Adds a sequential winner-scan mode with tie detection.
- Sits between the vote tally registers and the result display LEDs.
- mode=0 is voting: acknowledges cast votes. mode=1 is result: shows a selected candidate's tally, or the winner.

Parameters:
NUM_CAND, 4, number of candidates (>=2)
CNT_W, 4, width of each candidate tally and of result
HOLD_CYCLES, 10, cycles the vote-acknowledge pattern is held (>=1)
IDX_W, $clog2(NUM_CAND), localparam, candidate index width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
mode  in  1  0 = vote mode, 1 = result mode
valid_vote_casted  in  1  single-cycle pulse from the vote logger
cand_votes  in  NUM_CAND*CNT_W  packed tallies; candidate i at [i*CNT_W +: CNT_W]
cand_button_press  in  NUM_CAND  candidate buttons, bit i = candidate i
show_winner  in  1  pulse: start winner scan (result mode only)
result  out  CNT_W  display value
result_idx  out  IDX_W  index of the candidate shown
result_valid  out  1  result/result_idx hold a candidate tally
vote_ack  out  1  high while the acknowledge pattern is shown
tie  out  1  winner scan found more than one candidate at the maximum

Behaviour:
- Reset (async): state = VOTE, hold counter = 0, all outputs = 0.
- All outputs are registered. Each output updates on the clock edge after the condition that causes it.
- States: VOTE, ACK, RESULT, SCAN, WINNER.
- VOTE: result = 0, vote_ack = 0, result_valid = 0. valid_vote_casted goes to ACK.
- ACK:
  - result = all ones, vote_ack = 1 for exactly HOLD_CYCLES cycles, then VOTE.
  - A new valid_vote_casted during ACK restarts the count; the hold is extended, not stacked.
- mode=1 seen in VOTE or ACK: go to RESULT next cycle. This aborts ACK. result = 0, vote_ack = 0, result_valid = 0.
- RESULT:
  - Any button press latches the lowest-index asserted button into sel_idx.
  - From the next cycle: result = live tally of sel_idx, result_idx = sel_idx, result_valid = 1.
  - The display follows tally changes every cycle until another press.
  - No press keeps the previous selection.
  - valid_vote_casted is ignored in result mode.
- show_winner in RESULT or WINNER: go to SCAN. show_winner takes priority over a simultaneous button press.
- SCAN:
  - Visits index 0..NUM_CAND-1, one per cycle, taking exactly NUM_CAND cycles. result_valid = 0 throughout.
  - Index 0 initialises max = v0, widx = 0, tie = 0.
  - Each later index: if v > max, then max = v, widx = i, tie = 0. Else if v == max, tie = 1.
  - Comparison is unsigned.
  - Buttons and show_winner are ignored during SCAN.
  - Scan results reach the outputs in the cycle after the last visit. State goes to WINNER.
- WINNER:
  - result = max, result_idx = widx, result_valid = 1, tie as computed.
  - Values are frozen snapshots, not live.
  - A button press goes to RESULT with that selection and clears tie.
- mode=0 seen in RESULT, SCAN or WINNER: go to VOTE next cycle. This aborts any scan. All outputs = 0 and the hold counter is cleared.
- A valid_vote_casted in the same cycle as the 1->0 mode change is ignored.
- Reset mid-scan or mid-ACK: immediate return to reset values, no residual state.
- Hold counter width is $clog2(HOLD_CYCLES+1). It never wraps.

Test Plan:
- Reset, mode=0, one valid_vote_casted pulse (HOLD_CYCLES=10): result=4'b1111 and vote_ack=1 for exactly 10 cycles, then result=0.
- Second pulse at ACK cycle 6: the acknowledge lasts 10 cycles from the second pulse (15 total). Then mode->1 mid-ACK: next cycle vote_ack=0, result=0, result_valid=0.
- mode=1, tallies {3,7,2,9}, buttons 4'b0110 pressed together: result=7, result_idx=1, result_valid=1. Change tally 1 to 8: result=8 next cycle.
- Tallies {3,7,2,9}, show_winner pulse: result_valid=0 for 4 cycles, then result=9, result_idx=3, tie=0. Repeat with {9,7,9,1}: result=9, result_idx=0, tie=1.
- mode->0 on scan cycle 2: next cycle state VOTE, all outputs 0. A valid_vote_casted in that same cycle produces no acknowledge.
- Assert reset asynchronously mid-WINNER: outputs 0 immediately, before the next clock edge. Release: VOTE behaviour resumes normally.
